// File: rtl/vga_text_pixel_gen.sv
// Text-mode pixel source: VRAM cell fetch, font row fetch and palette/cursor colouring
// in a fixed 3-stage pipeline, with the screen position delayed to stay aligned with colour.
module vga_text_pixel_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  pixel_counter,
  input  logic [9:0]  line_counter,
  output logic [11:0] vram_addr,
  input  logic [15:0] vram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [7:0]  color_out,
  output logic [9:0]  pixel_out,
  output logic [9:0]  line_out
);
  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic        clr;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [3:0]  glyph_row;
  logic        active;
  logic [11:0] cell_addr;
  logic        cell_hit;
  logic        frame_start;

  // Stage 0 state
  logic        active_s0;
  logic [2:0]  pix_lo_s0;
  logic [3:0]  glyph_row_s0;
  logic        cell_hit_s0;
  logic [9:0]  pixel_s0;
  logic [9:0]  line_s0;
  logic [BW-1:0] blink_cnt;
  logic        blink_on;

  // Stage 1 state
  logic        active_s1;
  logic [2:0]  pix_lo_s1;
  logic [3:0]  fg_s1;
  logic [3:0]  bg_s1;
  logic        hit_s1;
  logic [9:0]  pixel_s1;
  logic [9:0]  line_s1;

  // Stage 2 combinational colour
  logic        pix_on;
  logic [3:0]  fg_eff;
  logic [3:0]  bg_eff;
  logic [7:0]  color_next;

  function automatic logic [7:0] palette(input logic [3:0] idx);
    logic [2:0] lvl;
    logic [1:0] blvl;
    lvl  = idx[3] ? 3'b111 : 3'b101;
    blvl = idx[3] ? 2'b11 : 2'b10;
    if (idx == 4'd8) begin
      palette = 8'b010_010_01;
    end else begin
      palette = {idx[2] ? lvl : 3'b000, idx[1] ? lvl : 3'b000, idx[0] ? blvl : 2'b00};
    end
  endfunction

  assign clr         = reset || !enable;
  assign col         = pixel_counter[9:3];
  assign row         = line_counter[8:4];
  assign glyph_row   = line_counter[3:0];
  assign active      = (pixel_counter < 10'(H_ACTIVE)) && (line_counter < 10'(V_ACTIVE));
  assign cell_addr   = 12'(row) * 12'(COLS) + 12'(col);
  assign frame_start = (pixel_counter == 10'd0) && (line_counter == 10'd0);

  // Out-of-range cursor coordinates are explicitly excluded so they can never match.
  assign cell_hit = (col == cursor_col) && (row == cursor_row) &&
                    (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS) &&
                    (glyph_row >= 4'd14);

  always_ff @(posedge clk) begin
    if (clr) begin
      vram_addr    <= '0;
      active_s0    <= 1'b0;
      pix_lo_s0    <= '0;
      glyph_row_s0 <= '0;
      cell_hit_s0  <= 1'b0;
      pixel_s0     <= '0;
      line_s0      <= '0;
    end else begin
      vram_addr    <= active ? cell_addr : 12'd0;
      active_s0    <= active;
      pix_lo_s0    <= pixel_counter[2:0];
      glyph_row_s0 <= glyph_row;
      cell_hit_s0  <= cell_hit;
      pixel_s0     <= pixel_counter;
      line_s0      <= line_counter;
    end
  end

  // Blink restarts in the visible half after any clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      font_addr <= '0;
      active_s1 <= 1'b0;
      pix_lo_s1 <= '0;
      fg_s1     <= '0;
      bg_s1     <= '0;
      hit_s1    <= 1'b0;
      pixel_s1  <= '0;
      line_s1   <= '0;
    end else begin
      font_addr <= {vram_data[7:0], glyph_row_s0};
      active_s1 <= active_s0;
      pix_lo_s1 <= pix_lo_s0;
      fg_s1     <= vram_data[11:8];
      bg_s1     <= vram_data[15:12];
      hit_s1    <= cursor_en && blink_on && cell_hit_s0;
      pixel_s1  <= pixel_s0;
      line_s1   <= line_s0;
    end
  end

  always_comb begin
    pix_on     = font_data[3'd7 - pix_lo_s1];
    fg_eff     = hit_s1 ? bg_s1 : fg_s1;
    bg_eff     = hit_s1 ? fg_s1 : bg_s1;
    color_next = 8'h00;
    if (active_s1) begin
      color_next = palette(pix_on ? fg_eff : bg_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      color_out <= '0;
      pixel_out <= '0;
      line_out  <= '0;
    end else begin
      color_out <= color_next;
      pixel_out <= pixel_s1;
      line_out  <= line_s1;
    end
  end

endmodule

// File: tb/tb_vga_text_pixel_gen.sv
// Self-checking bench for vga_text_pixel_gen: directed scenarios plus randomized traffic
// checked against a screen-level model of text cells, glyphs, palette, cursor and blink.
module tb_vga_text_pixel_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  pixel_counter;
  logic [9:0]  line_counter;
  logic [11:0] vram_addr;
  logic [15:0] vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [7:0]  color_out;
  logic [9:0]  pixel_out;
  logic [9:0]  line_out;

  logic [15:0] vram [0:4095];
  logic [7:0]  font_mem [0:4095];

  typedef struct packed {
    logic [7:0] c;
    logic [9:0] p;
    logic [9:0] l;
  } exp_t;

  exp_t exp_q[$];
  int   frames;
  int   checks;
  int   passes;

  vga_text_pixel_gen dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_counter(pixel_counter), .line_counter(line_counter),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .color_out(color_out), .pixel_out(pixel_out), .line_out(line_out)
  );

  always #5 clk = ~clk;

  // Memories answer in the cycle after their address register updates.
  assign vram_data = vram[vram_addr];
  assign font_data = font_mem[font_addr];

  function automatic logic [7:0] pal(input int i);
    int r, g, b;
    if (i == 8) return 8'h49;
    r = ((i & 4) != 0) ? (((i & 8) != 0) ? 7 : 5) : 0;
    g = ((i & 2) != 0) ? (((i & 8) != 0) ? 7 : 5) : 0;
    b = ((i & 1) != 0) ? (((i & 8) != 0) ? 3 : 2) : 0;
    return 8'(r * 32 + g * 4 + b);
  endfunction

  function automatic logic [7:0] model_color(input int p, input int l);
    int  attr, ch, fg, bg, gr, bits, on, tmp;
    bit  hit;
    if (p >= 640 || l >= 480) return 8'h00;
    attr = int'(vram[(l / 16) * 80 + p / 8]);
    ch   = attr % 256;
    fg   = (attr / 256) % 16;
    bg   = attr / 4096;
    gr   = l % 16;
    bits = int'(font_mem[ch * 16 + gr]);
    on   = (bits >> (7 - p % 8)) & 1;
    hit  = (cursor_en == 1'b1) && ((frames / 30) % 2 == 0) &&
           (p / 8 == int'(cursor_col)) && (l / 16 == int'(cursor_row)) && (gr >= 14);
    if (hit) begin
      tmp = fg; fg = bg; bg = tmp;
    end
    return pal((on != 0) ? fg : bg);
  endfunction

  // Drive one cycle of counters, advance the clock, and hand back the output triple
  // alongside the model's prediction for the counters applied three cycles earlier.
  task automatic step(input logic [9:0] p, input logic [9:0] l, input logic en,
                      input logic rst, output exp_t got, output exp_t want, output bit rdy);
    exp_t e;
    pixel_counter = p;
    line_counter  = l;
    enable        = en;
    reset         = rst;
    e = '0;
    if (rst || !en) begin
      frames = 0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
    end else begin
      if (p == 10'd0 && l == 10'd0) frames++;
      e.c = model_color(int'(p), int'(l));
      e.p = p;
      e.l = l;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rdy  = 1'b0;
    got  = '0;
    want = '0;
    if (exp_q.size() >= 3) begin
      want = exp_q.pop_front();
      got  = {color_out, pixel_out, line_out};
      rdy  = 1'b1;
    end
  endtask

  task automatic test_reset();
    exp_t got, want;
    bit   rdy;
    for (int i = 0; i < 5; i++) begin
      step(10'(100 + i), 10'd20, 1'b1, 1'b1, got, want, rdy);
      checks++;
      if (got !== 28'd0)
        $display("FAIL reset_hold cyc%0d: got c=%h p=%0d l=%0d want all 0", i, got.c, got.p, got.l);
      else passes++;
    end
    for (int i = 0; i < 12; i++) begin
      step(10'(105 + i), 10'd20, 1'b1, 1'b0, got, want, rdy);
      if (rdy) begin
        checks++;
        if (got !== want)
          $display("FAIL reset_release: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                   got.c, got.p, got.l, want.c, want.p, want.l);
        else passes++;
        $display("txn reset_release p=%0d l=%0d color=%h", got.p, got.l, got.c);
      end
    end
  endtask

  task automatic test_addressing();
    exp_t got, want;
    bit   rdy;
    logic [7:0] lit;
    vram[81]         = 16'h1F41;
    font_mem[12'h410] = 8'h80;
    cursor_en = 1'b0;
    step(10'd1, 10'd1, 1'b1, 1'b1, got, want, rdy);
    for (int i = 0; i < 11; i++) begin
      step(10'(8 + i), 10'd16, 1'b1, 1'b0, got, want, rdy);
      if (i == 0) begin
        checks++;
        if (vram_addr !== 12'd81) $display("FAIL vram_addr: got %0d want 81", vram_addr);
        else passes++;
      end
      if (i == 1) begin
        checks++;
        if (font_addr !== 12'h410) $display("FAIL font_addr: got %h want 410", font_addr);
        else passes++;
      end
      if (rdy) begin
        checks++;
        if (got !== want)
          $display("FAIL addressing: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                   got.c, got.p, got.l, want.c, want.p, want.l);
        else passes++;
        if (want.l == 10'd16 && want.p >= 10'd8 && want.p <= 10'd15) begin
          lit = (want.p == 10'd8) ? 8'hFF : 8'h02;
          checks++;
          if (got.c !== lit) $display("FAIL glyph_bit p=%0d: got %h want %h", want.p, got.c, lit);
          else passes++;
        end
        $display("txn addressing p=%0d l=%0d color=%h", got.p, got.l, got.c);
      end
    end
  endtask

  task automatic test_inactive();
    exp_t got, want;
    bit   rdy;
    logic [9:0] ps [0:9];
    logic [9:0] ls [0:9];
    ps = '{10'd638, 10'd639, 10'd640, 10'd641, 10'd0, 10'd5, 10'd799, 10'd1, 10'd2, 10'd3};
    ls = '{10'd10, 10'd10, 10'd10, 10'd10, 10'd480, 10'd481, 10'd524, 10'd1, 10'd1, 10'd1};
    step(10'd1, 10'd1, 1'b1, 1'b1, got, want, rdy);
    for (int i = 0; i < 10; i++) begin
      step(ps[i], ls[i], 1'b1, 1'b0, got, want, rdy);
      if (rdy) begin
        checks++;
        if (got !== want)
          $display("FAIL inactive: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                   got.c, got.p, got.l, want.c, want.p, want.l);
        else passes++;
        if (want.p >= 10'd640 || want.l >= 10'd480) begin
          checks++;
          if (got.c !== 8'h00) $display("FAIL blanking p=%0d l=%0d: got %h want 00", want.p, want.l, got.c);
          else passes++;
        end
        $display("txn inactive p=%0d l=%0d color=%h", got.p, got.l, got.c);
      end
    end
  endtask

  task automatic test_cursor();
    exp_t got, want;
    bit   rdy;
    logic [9:0] ps [0:7];
    logic [9:0] ls [0:7];
    logic [7:0] lit;
    ps = '{10'd80, 10'd81, 10'd87, 10'd80, 10'd88, 10'd1, 10'd1, 10'd1};
    ls = '{10'd46, 10'd46, 10'd47, 10'd45, 10'd46, 10'd1, 10'd1, 10'd1};
    vram[170] = 16'h0700;
    font_mem[13] = 8'h00;
    font_mem[14] = 8'h00;
    font_mem[15] = 8'h00;
    cursor_en  = 1'b1;
    cursor_col = 7'd10;
    cursor_row = 5'd2;
    step(10'd1, 10'd1, 1'b1, 1'b1, got, want, rdy);
    for (int i = 0; i < 8; i++) begin
      step(ps[i], ls[i], 1'b1, 1'b0, got, want, rdy);
      if (rdy) begin
        checks++;
        if (got !== want)
          $display("FAIL cursor: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                   got.c, got.p, got.l, want.c, want.p, want.l);
        else passes++;
        if (want.p >= 10'd80 && want.p <= 10'd87 && (want.l == 10'd45 || want.l == 10'd46 || want.l == 10'd47)) begin
          lit = (want.l == 10'd45) ? 8'h00 : 8'hB6;
          checks++;
          if (got.c !== lit) $display("FAIL cursor_cell p=%0d l=%0d: got %h want %h", want.p, want.l, got.c, lit);
          else passes++;
        end
        $display("txn cursor p=%0d l=%0d color=%h", got.p, got.l, got.c);
      end
    end
  endtask

  task automatic test_blink();
    exp_t got, want;
    bit   rdy;
    int   probe;
    int   nzero [0:3];
    logic [7:0] plit [0:3];
    nzero = '{29, 1, 29, 1};
    plit  = '{8'hB6, 8'h00, 8'h00, 8'hB6};
    probe = 0;
    step(10'd1, 10'd1, 1'b1, 1'b1, got, want, rdy);
    for (int ph = 0; ph < 5; ph++) begin
      for (int k = 0; k < ((ph < 4) ? nzero[ph] + 1 : 3); k++) begin
        if (ph == 4) step(10'd1, 10'd1, 1'b1, 1'b0, got, want, rdy);
        else if (k < nzero[ph]) step(10'd0, 10'd0, 1'b1, 1'b0, got, want, rdy);
        else step(10'd80, 10'd46, 1'b1, 1'b0, got, want, rdy);
        if (rdy) begin
          checks++;
          if (got !== want)
            $display("FAIL blink: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                     got.c, got.p, got.l, want.c, want.p, want.l);
          else passes++;
          if (want.p == 10'd80 && want.l == 10'd46 && probe < 4) begin
            checks++;
            if (got.c !== plit[probe])
              $display("FAIL blink_probe%0d: got %h want %h", probe, got.c, plit[probe]);
            else passes++;
            $display("txn blink probe=%0d color=%h", probe, got.c);
            probe++;
          end
        end
      end
    end
    checks++;
    if (probe != 4) $display("FAIL blink_probe_count: got %0d want 4", probe);
    else passes++;
  endtask

  task automatic test_enable_drop();
    exp_t got, want;
    bit   rdy;
    logic en;
    step(10'd1, 10'd1, 1'b1, 1'b1, got, want, rdy);
    for (int i = 0; i < 30; i++) begin
      en = !(i == 15 || i == 16);
      step(10'(i * 7), 10'd100, en, 1'b0, got, want, rdy);
      if (!en) begin
        checks++;
        if (got !== 28'd0)
          $display("FAIL enable_low cyc%0d: got c=%h p=%0d l=%0d want all 0", i, got.c, got.p, got.l);
        else passes++;
      end
      if (rdy) begin
        checks++;
        if (got !== want)
          $display("FAIL enable_refill: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                   got.c, got.p, got.l, want.c, want.p, want.l);
        else passes++;
        $display("txn enable_drop p=%0d l=%0d color=%h", got.p, got.l, got.c);
      end
    end
  endtask

  task automatic test_random();
    exp_t got, want;
    bit   rdy;
    logic [9:0] p, l;
    logic en, rst;
    int   errs;
    errs = 0;
    cursor_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        cursor_col = 7'($urandom_range(89));
        cursor_row = 5'($urandom_range(31));
      end
      if ($urandom_range(1) == 0) begin
        p = 10'(int'(cursor_col) * 8 + int'($urandom_range(7)));
        l = 10'(int'(cursor_row) * 16 + int'($urandom_range(15)));
      end else if ($urandom_range(15) == 0) begin
        p = 10'd0;
        l = 10'd0;
      end else begin
        p = 10'($urandom_range(799));
        l = 10'($urandom_range(524));
      end
      rst = (i == 0) || ($urandom_range(199) == 0);
      en  = ($urandom_range(99) != 0);
      step(p, l, en, rst, got, want, rdy);
      if (rdy) begin
        checks++;
        if (got !== want) begin
          errs++;
          if (errs <= 10)
            $display("FAIL random cyc%0d: got c=%h p=%0d l=%0d want c=%h p=%0d l=%0d",
                     i, got.c, got.p, got.l, want.c, want.p, want.l);
        end else passes++;
      end
    end
    $display("txn random cycles=3000 mismatches=%0d", errs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    passes = 0;
    frames = 0;
    reset = 1'b1;
    enable = 1'b1;
    pixel_counter = '0;
    line_counter = '0;
    cursor_en = 1'b0;
    cursor_col = '0;
    cursor_row = '0;
    for (int i = 0; i < 4096; i++) begin
      vram[i]     = 16'($urandom);
      font_mem[i] = 8'($urandom);
    end
    test_reset();
    test_addressing();
    test_inactive();
    test_cursor();
    test_blink();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
